systolic_skew_feeder: RTL

Operand feeder that sits directly upstream of the systolic MAC array and drives its left-edge A inputs. It holds one DIM x DIM signed matrix loaded row by row. On start it streams the matrix into the array with diagonal skew: array row i receives its k-th operand i cycles later than row 0 receives its k-th. The en input has the same stall meaning as the MAC cells' en, so the feeder and the array advance in lockstep.

---
 rtl/systolic_skew_feeder_if.sv | 19 +
 rtl/systolic_skew_feeder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Handshake/data bundle between the operand source and the systolic skew feeder.
interface systolic_skew_feeder_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                   WrEn;
  logic [AW-1:0]          wr_row;
  logic [DIM*BITS_AB-1:0] Ain;
  logic                   start;
  logic                   en;
  logic [DIM*BITS_AB-1:0] Aout;
  logic                   busy;
  logic                   done;

  modport master (output WrEn, wr_row, Ain, start, en, input  Aout, busy, done);
  modport slave  (input  WrEn, wr_row, Ain, start, en, output Aout, busy, done);
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonally skewed operand feeder for the systolic MAC array left edge.
// Define SKEW_FEEDER_TRANSPOSE_EN to stream columns instead of rows (top-edge B feed).
module systolic_skew_lane #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int LANE    = 0,
  parameter int TW      = $clog2(2*DIM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        beat,
  input  logic                        clr,
  input  logic [TW-1:0]               t,
  input  logic [DIM-1:0][BITS_AB-1:0] src,
  output logic [BITS_AB-1:0]          aout
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  // d = t - LANE with a borrow bit; lane is live only while 0 <= d < DIM
  logic [TW:0] d;
  logic        hit;
  assign d   = {1'b0, t} - (TW+1)'(LANE);
  assign hit = !d[TW] && (d[TW-1:0] < TW'(DIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    aout <= '0;
    else if (beat) aout <= hit ? src[d[AW-1:0]] : '0;
    else if (clr)  aout <= '0;
  end
endmodule

module systolic_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  systolic_skew_feeder_if.slave bus
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW = $clog2(2*DIM);
  localparam logic [TW-1:0] TLAST = TW'(2*DIM-2);
  localparam logic [AW:0]   ROWS  = (AW+1)'(DIM);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                                  state_q, state_d;
  logic [TW-1:0]                           t_q, t_d;
  logic                                    done_q, done_d;
  logic                                    beat, clr, wr_ok;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0]    a_q;   // [row][col]
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0]    src;   // per-lane operand source
  logic [DIM-1:0][BITS_AB-1:0]             ain_row;
  logic [DIM-1:0][BITS_AB-1:0]             aout_lane;

  assign ain_row = bus.Ain;
  // Writes only land in IDLE so the matrix is frozen for the whole stream
  assign wr_ok   = bus.WrEn && (state_q == IDLE) && ({1'b0, bus.wr_row} < ROWS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     a_q <= '0;
    else if (wr_ok) a_q[bus.wr_row] <= ain_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    beat    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = STREAM;
        t_d     = '0;
      end
      STREAM: if (bus.en) begin
        beat = 1'b1;
        t_d  = t_q + TW'(1);
        if (t_q == TLAST) state_d = FLUSH;
      end
      FLUSH: if (bus.en) begin
        clr     = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < DIM; i++) begin : g_lane
`ifdef SKEW_FEEDER_TRANSPOSE_EN
      for (genvar j = 0; j < DIM; j++) begin : g_col
        assign src[i][j] = a_q[j][i];
      end
`else
      assign src[i] = a_q[i];
`endif
      systolic_skew_lane #(
        .BITS_AB(BITS_AB), .DIM(DIM), .LANE(i), .TW(TW)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .beat (beat),
        .clr  (clr),
        .t    (t_q),
        .src  (src[i]),
        .aout (aout_lane[i])
      );
    end
  endgenerate

  assign bus.Aout = aout_lane;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
endmodule
